// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one sprite ROM read port between N_REQ pixel
// requesters and returns each palette index tagged with the requester id.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AW      = 11,
  parameter int DW      = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                     vga_clk,
  input  logic                     Reset,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AW-1:0]      req_addr,
  output logic [N_REQ-1:0]         gnt,
  output logic [AW-1:0]            rom_address,
  input  logic [DW-1:0]            rom_q,
  output logic                     rd_valid,
  output logic [$clog2(N_REQ)-1:0] rd_id,
  output logic [DW-1:0]            rd_data,
  output logic                     busy
);

  localparam int             IW      = $clog2(N_REQ);
  localparam int             DEPTH   = ROM_LAT + 1;
  localparam logic [IW:0]    NREQ_W  = (IW+1)'(N_REQ);
  localparam logic [IW-1:0]  LAST_ID = IW'(N_REQ - 1);

  logic [IW-1:0]             r_ptr;
  logic [AW-1:0]             r_romAddr;
  logic [DEPTH-1:0]          r_tagValid;
  logic [DEPTH-1:0][IW-1:0]  r_tagId;

  logic                      w_found;
  logic [IW-1:0]             w_winner;
  logic [N_REQ-1:0]          w_gnt;
  logic                      w_xfer;
  logic [AW-1:0]             w_addrSel;
  logic [IW-1:0]             w_tagIdIn;
  logic [IW-1:0]             w_ptrNext;

  // Search from the pointer upwards, wrapping past N_REQ-1 back to 0.
  always_comb begin
    logic [IW:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!w_found && req[idx[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (!Reset && en && w_found) w_gnt[w_winner] = 1'b1;
  end

  assign w_xfer    = |(req & w_gnt);
  assign w_addrSel = req_addr[w_winner*AW +: AW];
  assign w_tagIdIn = w_xfer ? w_winner : '0;
  assign w_ptrNext = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;

  // Tags travel alongside the ROM access so rd_id lines up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_ptr      <= '0;
      r_romAddr  <= '0;
      r_tagValid <= '0;
      r_tagId    <= '0;
    end else begin
      r_tagValid <= {r_tagValid[DEPTH-2:0], w_xfer};
      r_tagId    <= {r_tagId[DEPTH-2:0], w_tagIdIn};
      if (w_xfer) begin
        r_romAddr <= w_addrSel;
        r_ptr     <= w_ptrNext;
      end
    end
  end

  assign gnt         = w_gnt;
  assign rom_address = r_romAddr;
  assign rd_valid    = r_tagValid[DEPTH-1];
  assign rd_id       = r_tagId[DEPTH-1];
  assign rd_data     = rom_q;
  assign busy        = |r_tagValid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed vector table, a streaming
// sequence and randomized traffic, all checked against a queue-based model.
module tb_sprite_rom_arbiter;

  localparam int N_REQ   = 4;
  localparam int AW      = 11;
  localparam int DW      = 5;
  localparam int ROM_LAT = 1;
  localparam int IW      = $clog2(N_REQ);

  logic                vga_clk = 1'b0;
  logic                Reset;
  logic                en;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    gnt;
  logic [AW-1:0]       rom_address;
  logic [DW-1:0]       rom_q;
  logic                rd_valid;
  logic [IW-1:0]       rd_id;
  logic [DW-1:0]       rd_data;
  logic                busy;

  sprite_rom_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q), .rd_valid(rd_valid),
    .rd_id(rd_id), .rd_data(rd_data), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [DW-1:0] romFn(input logic [AW-1:0] a);
    return DW'(a * 13 + (a >> 5) + 7);
  endfunction

  // Behavioural sprite ROM with ROM_LAT cycles from address to q.
  logic [DW-1:0] romPipe [ROM_LAT];
  always @(posedge vga_clk) begin
    romPipe[0] <= romFn(rom_address);
    for (int k = 1; k < ROM_LAT; k++) romPipe[k] <= romPipe[k-1];
  end
  assign rom_q = romPipe[ROM_LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } readT;

  typedef struct {
    logic             rst;
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rv;
    int               rid;
  } vecT;

  readT             pending[$];
  vecT              vecs[$];
  logic [AW-1:0]    addrs [N_REQ];
  int               mPtr;
  logic [AW-1:0]    mAddr;
  logic [N_REQ-1:0] expGnt;
  int               cur;
  int               total = 0;
  int               bad = 0;
  logic [N_REQ-1:0] sGnt;
  logic             sValid;
  logic [IW-1:0]    sId;
  logic [AW-1:0]    sAddr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cur, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic applyStimulus(input logic rst, input logic enI, input logic [N_REQ-1:0] reqI);
    int            win;
    logic          expValid;
    int            expId;
    logic [DW-1:0] expData;
    @(negedge vga_clk);
    Reset = rst;
    en    = enI;
    req   = reqI;
    for (int i = 0; i < N_REQ; i++) req_addr[i*AW +: AW] = addrs[i];
    #1;
    win    = -1;
    expGnt = '0;
    if (!rst && enI)
      for (int k = 0; k < N_REQ; k++)
        if (win < 0 && reqI[(mPtr + k) % N_REQ]) win = (mPtr + k) % N_REQ;
    if (win >= 0) expGnt[win] = 1'b1;
    expValid = 1'b0;
    expId    = 0;
    expData  = '0;
    foreach (pending[j])
      if (pending[j].due == cur) begin
        expValid = 1'b1;
        expId    = pending[j].id;
        expData  = pending[j].data;
      end
    sGnt   = gnt;
    sValid = rd_valid;
    sId    = rd_id;
    sAddr  = rom_address;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("rom_address", 32'(rom_address), 32'(mAddr));
    checkOutput("rd_valid", 32'(rd_valid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(pending.size() > 0));
    if (expValid) begin
      checkOutput("rd_id", 32'(rd_id), 32'(expId));
      checkOutput("rd_data", 32'(rd_data), 32'(expData));
    end
    if (rst) begin
      mPtr  = 0;
      mAddr = '0;
      pending.delete();
    end else if (win >= 0) begin
      mAddr = addrs[win];
      mPtr  = (win + 1) % N_REQ;
      pending.push_back('{cur + ROM_LAT + 1, win, romFn(addrs[win])});
    end
    @(posedge vga_clk);
    cur++;
    while (pending.size() > 0 && pending[0].due < cur) void'(pending.pop_front());
  endtask

  initial begin
    logic [N_REQ-1:0] rq;
    logic [N_REQ-1:0] prevReq;
    logic [N_REQ-1:0] prevGnt;
    logic             rr;
    logic             ee;

    Reset = 1'b1;
    en    = 1'b0;
    req   = '0;
    for (int i = 0; i < N_REQ; i++) addrs[i] = AW'(100 + 10 * i);
    req_addr = '0;
    repeat (3) @(posedge vga_clk);
    mPtr  = 0;
    mAddr = '0;
    cur   = 0;

    @(negedge vga_clk);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rom_address", 32'(rom_address), 32'd0);
    checkOutput("reset rd_id", 32'(rd_id), 32'd0);
    checkOutput("reset gnt", 32'(gnt), 32'd0);

    vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 2});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1, 3});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1, 2});
    vecs.push_back('{1'b0, 1'b1, 4'b1001, 4'b1000, 1'b1, 3});
    vecs.push_back('{1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1, 2});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'b0010, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0});

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].req);
      checkOutput($sformatf("vec%0d gnt", v), 32'(sGnt), 32'(vecs[v].gnt));
      checkOutput($sformatf("vec%0d rd_valid", v), 32'(sValid), 32'(vecs[v].rv));
      if (vecs[v].rv) checkOutput($sformatf("vec%0d rd_id", v), 32'(sId), 32'(vecs[v].rid));
    end

    // Requester 2 streaming fresh addresses back to back.
    addrs[2] = 11'd5;
    applyStimulus(1'b0, 1'b1, 4'b0100);
    checkOutput("stream gnt0", 32'(sGnt), 32'b0100);
    addrs[2] = 11'd6;
    applyStimulus(1'b0, 1'b1, 4'b0100);
    checkOutput("stream gnt1", 32'(sGnt), 32'b0100);
    checkOutput("stream addr0", 32'(sAddr), 32'd5);
    addrs[2] = 11'd7;
    applyStimulus(1'b0, 1'b1, 4'b0100);
    checkOutput("stream gnt2", 32'(sGnt), 32'b0100);
    checkOutput("stream addr1", 32'(sAddr), 32'd6);
    checkOutput("stream rv0", 32'(sValid), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("stream addr2", 32'(sAddr), 32'd7);
    checkOutput("stream rv1", 32'(sValid), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("stream rv2", 32'(sValid), 32'd1);
    checkOutput("stream rid2", 32'(sId), 32'd2);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("stream rv3", 32'(sValid), 32'd0);

    // Random traffic: held requests mostly stay up, some drop before grant.
    prevReq = '0;
    prevGnt = '0;
    for (int n = 0; n < 500; n++) begin
      rr = ($urandom_range(0, 59) == 0);
      ee = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (prevReq[i] && !prevGnt[i]) rq[i] = ($urandom_range(0, 9) != 0);
        else                           rq[i] = ($urandom_range(0, 2) != 0);
        if (!prevReq[i] || prevGnt[i])
          addrs[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      end
      applyStimulus(rr, ee, rq);
      prevReq = rq;
      prevGnt = sGnt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Round-robin arbiter sharing one sprite ROM read port between up to N_REQ pixel requesters (snake head, body, food, score text mappers).
- Each requester presents a ROM address with a valid/ready handshake.
- The arbiter drives the shared ROM address and returns the ROM palette index tagged with the requester ID.
- Sits between the per-sprite mappers and the single sprite ROM instance, in the vga_clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 11, ROM address width.
- DW, 5, ROM data (palette index) width.
- ROM_LAT, 1, ROM read latency in cycles, counted from registered address to q valid (1..3).

Ports:
- vga_clk  in  1  pixel clock; all state on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- en  in  1  grant enable; when low, no grants are issued and in-flight reads still complete.
- req  in  N_REQ  per-requester request; level, held until granted.
- req_addr  in  N_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]; must be stable while req[i] is high.
- gnt  out  N_REQ  one-hot combinational grant; a transfer occurs on an edge where req[i] and gnt[i] are both high.
- rom_address  out  AW  registered address to the shared ROM.
- rom_q  in  DW  ROM output.
- rd_valid  out  1  read data valid.
- rd_id  out  $clog2(N_REQ)  requester index of the current rd_data.
- rd_data  out  DW  equals rom_q (combinational pass-through); meaningful only when rd_valid is high.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (synchronous, active-high): rom_address=0, rd_valid=0, rd_id=0, busy=0, priority pointer=0, all in-flight tags cleared.
- gnt is combinational and is 0 whenever Reset=1 or en=0.
- Arbitration:
  - Winner = first i with req[i]=1, searching from pointer up to N_REQ-1 and wrapping to 0.
  - gnt is one-hot with at most one bit set; gnt=0 when req=0.
- On a transfer edge:
  - rom_address <= winner's address.
  - pointer <= (winner+1) mod N_REQ, with explicit wrap from N_REQ-1 to 0.
  - A tag {valid=1, id=winner} enters a ROM_LAT+1 deep shift register.
- With no transfer: the pointer holds, rom_address holds its last value, and a valid=0 tag is shifted in.
- Latency: a transfer in cycle C gives rd_valid=1 with rd_id=winner in cycle C+ROM_LAT+1, for exactly 1 cycle per transfer.
- Throughput: one transfer per cycle. A lone requester holding req with new addresses is granted every cycle. With all N_REQ requesting, each is granted exactly once per N_REQ cycles; the starvation bound is N_REQ-1 cycles.
- busy = OR of the valid bits in the tag shift register.
- Requester drops req before being granted: no grant and no read is issued for it; the pointer is unaffected.
- en falls with reads in flight: the pipeline drains normally, with rd_valid for each and no new grants.
- Reset while reads are in flight: all tags are cleared and rd_valid=0 from the next cycle; no stale data is reported.
- Simultaneous new requests and pipeline output: independent, no interaction.
- Identical addresses from two requesters: served as two separate transfers, with no merging.

Test Plan:
- Reset -> rd_valid=0, busy=0, rom_address=0. Then req=4'b0001, addr0=11'd100 at cycle 0 -> gnt=0001 in cycle 0, rom_address=100 from cycle 1, rd_valid=1 with rd_id=0 in cycle 2 (ROM_LAT=1), rd_data=rom_q.
- req=4'b1111 held for 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,... and rd_id sequence 0,1,2,3,0,... delayed by 2 cycles.
- Pointer at 3 (last grant was 2), req=4'b1001 -> gnt=1000; next cycle gnt=0001 (wrap from 3 to 0).
- Stream: requester 2 alone, addresses 5,6,7 on consecutive cycles -> 3 grants in 3 cycles, rom_address 5,6,7, rd_valid high for 3 consecutive cycles.
- en=0 with req=4'b0110 -> gnt=0 for all cycles and the pointer is unchanged. Setting en=1 -> gnt=0010.
- Reset asserted in the cycle after a transfer (read in flight) -> rd_valid stays 0 in cycle C+2 and busy=0.
